// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encoding, default
// sizing and the frame parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam int FIFO_DEPTH_DEF  = 8;
  localparam int TIMEOUT_CYC_DEF = 2500;

  // A PS/2 frame is good when the 8 data bits plus the parity bit hold an odd number of ones.
  function automatic logic frame_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous show-ahead scan-code buffer. The head entry is always on dout;
// a push into a full buffer is accepted only when a pop happens in the same cycle.
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W     = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Depth is a power of two, so pointer overflow is the modulo wrap.
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver: synchronizes the device lines, deframes 11-bit
// frames on falling ps2_clk edges and queues good scan codes for the bus.
module ps2_kbd
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       ps2_rd,
  output logic [7:0] key,
  output logic       ps2_ready,
  output logic       overflow,
  output logic       frame_err,
  output ps2_state_t dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          clk_s1, clk_s2, clk_prev;
  logic          data_s1, data_s2;
  logic          fall;
  logic          rd_prev, pop_req;

  ps2_state_t    state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par_bit, par_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          push;
  logic          ferr_n;

  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      rd_prev  <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
      rd_prev  <= ps2_rd;
    end
  end

  assign fall    = !clk_s2 && clk_prev;
  assign pop_req = ps2_rd && !rd_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      tmo       <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      par_bit   <= par_n;
      tmo       <= tmo_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_n     = par_bit;
    tmo_n     = tmo;
    push      = 1'b0;
    ferr_n    = 1'b0;

    case (state)
      ST_IDLE: begin
        tmo_n = '0;
        if (fall && !data_s2) begin
          state_n   = ST_DATA;
          bit_cnt_n = '0;
          shift_n   = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_n   = {data_s2, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_n   = data_s2;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_n = ST_IDLE;
          if (data_s2 && frame_parity_ok(shift, par_bit)) push   = 1'b1;
          else                                            ferr_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A stalled device must not wedge the receiver mid-frame.
    if (state != ST_IDLE) begin
      if (fall) begin
        tmo_n = '0;
      end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
        state_n   = ST_IDLE;
        tmo_n     = '0;
        bit_cnt_n = '0;
        shift_n   = '0;
        push      = 1'b0;
        ferr_n    = 1'b1;
      end else begin
        tmo_n = tmo + TW'(1);
      end
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shift),
    .pop   (pop_req),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Overflow latches on a dropped byte and clears on the next pop that removes an entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (pop_req && !fifo_empty) begin
      overflow <= 1'b0;
    end else if (push && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  assign ps2_ready = (fifo_count != '0);
  assign key       = ps2_ready ? fifo_dout : 8'h00;
  assign dbg_state = state;

endmodule
